// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and holds
// each word for decode. Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_rvalid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  output logic                  misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           branch_count
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic                    handshake;

  assign handshake = (state_q == HOLD) && instr_ready;
  // Wrap-around of the PC is intentionally silent.
  assign next_pc   = instr_pc_q + (PCsrc ? ImmOp : ADDR_WIDTH'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          if (next_pc[1:0] != 2'b00) begin
            state_d    = ERR;
            misalign_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  // The captured word stays visible in WAIT; decode ignores it there since instr_valid=0.
  assign instr       = ((state_q == WAIT) || (state_q == HOLD)) ? instr_q : NOP_INSTR;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (handshake) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (PCsrc) begin
        branch_cnt_d = branch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign branch_count = branch_cnt_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level PC/memory model drives
// randomized latencies, stalls, branches and spurious responses, plus directed corner cases.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] branch_count;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .misalign    (misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .branch_count(branch_count)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_pc;
  int          exp_fetches;
  int          exp_branches;
  bit          in_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    PCsrc       = 1'b0;
    ImmOp       = '0;
  endtask

  // Leaves the bench in the REQ cycle following reset release.
  task automatic do_reset();
    rst = 1'b1;
    quiet_inputs();
    step();
    step();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_instr_pc", instr_pc, RESET_PC);
    check("rst_valid", instr_valid, 0);
    check("rst_misalign", misalign, 0);
    rst = 1'b0;
    step();
    check("req_after_idle", imem_req, 1);
    exp_pc       = RESET_PC;
    exp_fetches  = 0;
    exp_branches = 0;
    in_err       = 1'b0;
  endtask

  // Entry: current cycle is expected to be REQ. Exit: cycle after the handshake.
  task automatic fetch(input int lat, input int hold, input bit take,
                       input logic [31:0] imm, input logic [31:0] data);
    logic [31:0] nxt;
    check("req", imem_req, 1);
    check("addr", imem_addr, exp_pc);
    check("nop_in_req", instr, NOP_INSTR);
    check("req_invalid", instr_valid, 0);
    imem_rvalid = $urandom_range(0, 1);
    imem_rdata  = $urandom;
    step();
    for (int i = 0; i < lat; i++) begin
      check("wait_noreq", imem_req, 0);
      check("wait_invalid", instr_valid, 0);
      imem_rvalid = (i == lat - 1);
      imem_rdata  = (i == lat - 1) ? data : $urandom;
      step();
    end
    imem_rvalid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, data);
      check("hold_pc", instr_pc, exp_pc);
      check("hold_noreq", imem_req, 0);
      if (h < hold) begin
        instr_ready = 1'b0;
        imem_rvalid = $urandom_range(0, 1);
        imem_rdata  = $urandom;
        PCsrc       = $urandom_range(0, 1);
        ImmOp       = $urandom;
      end else begin
        instr_ready = 1'b1;
        imem_rvalid = 1'b0;
        PCsrc       = take;
        ImmOp       = imm;
      end
      step();
    end
    quiet_inputs();
    nxt = exp_pc + (take ? imm : 32'd4);
    exp_fetches++;
    if (take) exp_branches++;
    $display("fetch pc=%h data=%h lat=%0d hold=%0d take=%0d imm=%h next=%h",
             exp_pc, data, lat, hold, take, imm, nxt);
    if (nxt[1:0] != 2'b00) begin
      in_err = 1'b1;
      check("err_misalign", misalign, 1);
      check("err_invalid", instr_valid, 0);
      check("err_noreq", imem_req, 0);
    end else begin
      exp_pc = nxt;
      check("no_misalign", misalign, 0);
    end
  endtask

  task automatic check_counters();
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, exp_fetches);
    check("branch_count", branch_count, exp_branches);
`endif
  endtask

  initial begin
    logic [31:0] imm;
    bit          take;
    quiet_inputs();
    do_reset();

    // Sequential stream at best-case throughput, then a 5-cycle stall at 0x0C.
    for (int k = 0; k < 3; k++) fetch(1, 0, 1'b0, 32'h0, 32'h0050_0093);
    fetch(1, 5, 1'b0, 32'h0, 32'h0010_0113);
    // Backward branch from 0x10 by -8 lands on 0x08.
    fetch(1, 0, 1'b1, 32'hFFFF_FFF8, 32'hFE00_0CE3);
    check("branch_target", imem_addr, 32'h0000_0008);
    // Slow memory with spurious responses while held.
    fetch(4, 3, 1'b0, 32'h0, 32'hDEAD_BEEF);
    check_counters();

    for (int n = 0; n < 40; n++) begin
      take = ($urandom_range(0, 2) == 0);
      imm  = 32'($signed($urandom_range(0, 63)) - 32) << 2;
      fetch($urandom_range(1, 4), $urandom_range(0, 3), take, imm, $urandom);
    end
    check_counters();

    // Reset while waiting on memory; the late response must be dropped.
    step();
    rst = 1'b1;
    step();
    check("midrst_valid", instr_valid, 0);
    check("midrst_req", imem_req, 0);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    exp_pc       = RESET_PC;
    exp_fetches  = 0;
    exp_branches = 0;
    check("postrst_instr", instr, NOP_INSTR);
    fetch(2, 0, 1'b0, 32'h0, 32'h1234_5673);
    fetch(1, 1, 1'b1, 32'h0000_0020, 32'h0200_0063);
    check_counters();

    // Misaligned branch target: terminal error until reset.
    fetch(1, 0, 1'b1, 32'h0000_0006, 32'h0060_0063);
    check("err_pc_held", imem_addr, exp_pc);
    for (int c = 0; c < 6; c++) begin
      instr_ready = 1'b1;
      PCsrc       = $urandom_range(0, 1);
      ImmOp       = $urandom;
      imem_rvalid = $urandom_range(0, 1);
      imem_rdata  = $urandom;
      step();
      check("err_noreq_hold", imem_req, 0);
      check("err_valid_hold", instr_valid, 0);
      check("err_sticky", misalign, 1);
      check("err_nop", instr, NOP_INSTR);
    end
    quiet_inputs();
    do_reset();
    fetch(1, 0, 1'b0, 32'h0, 32'h0050_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
